// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - register map, CTRL fields, MODE encodings and FSM states for timer_dev
package timer_dev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Only RELOAD changes behaviour; 2 and 3 act as ONESHOT.
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_IRQ  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped down-counter with one-shot/auto-reload modes and level irq
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = lanes[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       preset;
    logic [31:0]       count;
    logic              pending;
    timer_state_e      state;
    timer_state_e      state_next;
    logic [31:0]       count_next;
    logic              fsm_clr_en;
    logic              pend_set;
    logic              pend_drop;
    logic [1:0]        mode;
    logic              ctrl_wr;
    logic              preset_wr;

    assign mode      = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

    always_comb begin
        state_next = state;
        count_next = count;
        fsm_clr_en = 1'b0;
        pend_set   = 1'b0;
        pend_drop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl[CTRL_EN]) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                count_next = preset;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_next = ST_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // PRESET=0 lands here straight from LOAD, so it times out like PRESET=1.
                    count_next = '0;
                    state_next = ST_IRQ;
                    pend_set   = 1'b1;
                end
            end
            ST_IRQ: begin
                if (mode == MODE_RELOAD) begin
                    state_next = ST_LOAD;
                    pend_drop  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    fsm_clr_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (preset_wr) preset <= merge_bytes(preset, wd, be);
            // A CPU write to the CTRL byte overrides the FSM's own EN clear.
            if (ctrl_wr && be[0]) begin
                ctrl <= wd[CTRL_W-1:0];
            end else if (fsm_clr_en) begin
                ctrl[CTRL_EN] <= 1'b0;
            end
            if (pend_set) begin
                pending <= 1'b1;
            end else if (pend_drop || (ctrl_wr && (be != 4'd0))) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_CTRL:   rd = {{(32-CTRL_W){1'b0}}, ctrl};
            ADDR_PRESET: rd = preset;
            ADDR_COUNT:  rd = count;
            ADDR_RSVD:   rd = '0;
            default:     rd = '0;
        endcase
    end

    assign irq = pending && ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - vector table, directed corner sequences and randomized model check for timer_dev
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer_dev dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .be   (be),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [1:0]  addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [1:0] a, input logic w, input logic [3:0] b,
                           input logic [31:0] d, input logic c, input logic [31:0] er, input logic ei);
        vec_t v;
        v.rst = r; v.addr = a; v.we = w; v.be = b; v.wd = d;
        v.chk = c; v.exp_rd = er; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d);
        @(negedge clk);
        rst = r; addr = a; we = w; be = b; wd = d;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: registers plus one-hot activity flags (none set = idle).
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pend, m_loading, m_running, m_expired;

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [1:0] a, input logic w, input logic [3:0] b,
                              input logic [31:0] d);
        bit en, clr_en, set_p, drop_p, nl, nr, ne;
        logic [31:0] nc;
        if (r) begin
            m_ctrl = 0; m_preset = 0; m_count = 0; m_pend = 0;
            m_loading = 0; m_running = 0; m_expired = 0;
            return;
        end
        en = m_ctrl[0];
        clr_en = 0; set_p = 0; drop_p = 0; nl = 0; nr = 0; ne = 0;
        nc = m_count;
        if (m_loading) begin
            nc = m_preset; nr = 1;
        end else if (m_running) begin
            if (en) begin
                if (m_count > 1) begin nc = m_count - 1; nr = 1; end
                else begin nc = 0; ne = 1; set_p = 1; end
            end
        end else if (m_expired) begin
            if (m_ctrl[2:1] == 2'd1) begin nl = 1; drop_p = 1; end
            else clr_en = 1;
        end else if (en) begin
            nl = 1;
        end
        if (w && a == 2'd1)
            for (int i = 0; i < 4; i++) if (b[i]) m_preset[8*i +: 8] = d[8*i +: 8];
        if (w && a == 2'd0 && b[0]) m_ctrl = d[3:0];
        else if (clr_en) m_ctrl[0] = 1'b0;
        if (set_p) m_pend = 1;
        else if (drop_p || (w && a == 2'd0 && b != 0)) m_pend = 0;
        m_count = nc; m_loading = nl; m_running = nr; m_expired = ne;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; addr = 0; we = 0; be = 0; wd = 0;

        // Reset overriding a write, reads after reset, byte lanes, one-shot expiry.
        add_vec(1, 0, 1, 4'hF, 32'hFFFF_FFFF, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 1, 32'h0, 0);
        add_vec(0, 1, 0, 0, 0, 1, 32'h0, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'h0, 0);
        add_vec(0, 3, 1, 4'hF, 32'hFFFF_FFFF, 1, 32'h0, 0);
        add_vec(0, 3, 0, 0, 0, 1, 32'h0, 0);
        add_vec(0, 1, 1, 4'hF, 32'h0, 1, 32'h0, 0);
        add_vec(0, 1, 1, 4'h3, 32'h1234_5678, 1, 32'h0, 0);
        add_vec(0, 1, 0, 0, 0, 1, 32'h0000_5678, 0);
        add_vec(0, 2, 1, 4'hF, 32'h0000_FFFF, 1, 32'h0, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'h0, 0);
        add_vec(0, 1, 1, 4'hF, 32'd3, 1, 32'h0000_5678, 0);
        add_vec(0, 0, 1, 4'hF, 32'h9, 1, 32'h0, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'd0, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'd0, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'd3, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'd2, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'd1, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'd0, 1);
        add_vec(0, 0, 0, 0, 0, 1, 32'h8, 1);
        add_vec(0, 0, 1, 4'h1, 32'h8, 1, 32'h8, 1);
        add_vec(0, 0, 0, 0, 0, 1, 32'h8, 0);
        add_vec(0, 2, 0, 0, 0, 1, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wd);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
                check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            end
        end

        // Auto-reload: PRESET=2 gives a one-cycle irq every 4 cycles, EN stays set.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 4'hF, 32'd2);
        drive(0, 0, 1, 4'hF, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("reload_ctrl_k%0d", k), rd, 32'hB);
            check($sformatf("reload_irq_k%0d", k), {31'd0, irq},
                  {31'd0, (k >= 5) && ((k - 5) % 4 == 0)});
        end

        // Disable mid-count: write lands while COUNT=7, so COUNT holds 6; re-enable reloads 10.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 4'hF, 32'd10);
        drive(0, 0, 1, 4'hF, 32'h1);
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            drive(0, 2, 0, 0, 0);
            if (rd == 32'd7) begin
                seen = 1;
                addr = 2'd0; we = 1'b1; be = 4'hF; wd = 32'h0;
            end
        end
        check("hold_wait_count7", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 2, 0, 0, 0);
            check($sformatf("hold_count_k%0d", k), rd, 32'd6);
        end
        drive(0, 0, 1, 4'hF, 32'h1);
        check("hold_ctrl_off", rd, 32'h0);
        drive(0, 2, 0, 0, 0);
        check("reen_count_a", rd, 32'd6);
        drive(0, 2, 0, 0, 0);
        check("reen_count_b", rd, 32'd6);
        drive(0, 2, 0, 0, 0);
        check("reen_count_reload", rd, 32'd10);

        // Masked one-shot expiry, CPU re-enables in the IRQ cycle.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 4'hF, 32'd1);
        drive(0, 0, 1, 4'hF, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 2, 0, 0, 0);
            check($sformatf("mask_irq_k%0d", k), {31'd0, irq}, 32'd0);
        end
        drive(0, 0, 1, 4'hF, 32'h1);
        check("mask_irq_in_irq", {31'd0, irq}, 32'd0);
        drive(0, 0, 0, 0, 0);
        check("mask_cpu_wins_en", rd, 32'h1);
        check("mask_irq_after", {31'd0, irq}, 32'd0);
        drive(0, 2, 0, 0, 0);
        check("mask_restart_hold", rd, 32'd0);
        drive(0, 2, 0, 0, 0);
        check("mask_restart_count", rd, 32'd1);
        check("mask_restart_irq", {31'd0, irq}, 32'd0);

        // Reset mid-count aborts without irq.
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 4'hF, 32'd3);
        drive(0, 0, 1, 4'hF, 32'h9);
        drive(0, 2, 0, 0, 0);
        drive(0, 2, 0, 0, 0);
        drive(1, 2, 1, 4'hF, 32'h5);
        for (int k = 0; k < 8; k++) begin
            drive(0, 2'(k), 0, 0, 0);
            check($sformatf("abort_rd_k%0d", k), rd, 32'h0);
            check($sformatf("abort_irq_k%0d", k), {31'd0, irq}, 32'd0);
        end

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r, w;
            logic [1:0]  a;
            logic [3:0]  b;
            logic [31:0] d;
            r = ($urandom_range(0, 63) == 0);
            w = ($urandom_range(0, 3) == 0);
            a = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            d = $urandom;
            if (a == 2'd1 && $urandom_range(0, 15) != 0) d = 32'($urandom_range(0, 6));
            if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            drive(r, a, w, b, d);
            check($sformatf("rand%0d_rd", n), rd, model_rd(a));
            check($sformatf("rand%0d_irq", n), {31'd0, irq}, {31'd0, m_pend && m_ctrl[3]});
            model_step(r, a, w, b, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
